// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, timing defaults and helpers for the WS2812 driver
package ws2812_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  localparam int DEF_CLKHZ   = 100_000_000;
  localparam int DEF_T0H_NS  = 400;
  localparam int DEF_T1H_NS  = 800;
  localparam int DEF_TBIT_NS = 1250;
  localparam int DEF_TRST_US = 300;
  function automatic int ns2cyc(input longint clkhz, input longint ns);
    return int'(clkhz * ns / 64'sd1_000_000_000);
  endfunction
  function automatic logic [23:0] grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction
endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: per-bank GRB shift register and pulse-width comparator on the shared bit timer
module ws2812_bit_encoder #(
  parameter int CW  = 8,
  parameter int N0H = 40,
  parameter int N1H = 80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic          i_send,
  input  logic [23:0]   i_pix,
  input  logic [CW-1:0] i_cnt,
  output logic          o_dout
);
  localparam logic [CW-1:0] T0 = CW'(N0H);
  localparam logic [CW-1:0] T1 = CW'(N1H);
  logic [23:0] r_sr;
  logic        r_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_dout <= 1'b0;
    end else begin
      r_sr   <= i_load ? i_pix : i_shift ? {r_sr[22:0], 1'b0} : r_sr;
      r_dout <= i_send && (i_cnt < (r_sr[23] ? T1 : T0));
    end
  end
  assign o_dout = r_dout;
endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: parallel WS2812 chain driver; one shared FSM and bit timer, one encoder per bank
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int CLKHZ    = DEF_CLKHZ,
  parameter int BANK_NUM = 1,
  parameter int BANK_X   = 8,
  parameter int BANK_Y   = 8,
  parameter int T0H_NS   = DEF_T0H_NS,
  parameter int T1H_NS   = DEF_T1H_NS,
  parameter int TBIT_NS  = DEF_TBIT_NS,
  parameter int TRST_US  = DEF_TRST_US
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [23:0]         wscolor [BANK_NUM*BANK_X*BANK_Y],
  input  logic                en,
  output logic [BANK_NUM-1:0] dout,
  output logic                busy,
  output logic                frame_done
);
  localparam int NPIX = BANK_X * BANK_Y;
  localparam int NBIT = ns2cyc(CLKHZ, TBIT_NS);
  localparam int N0H  = ns2cyc(CLKHZ, T0H_NS);
  localparam int N1H  = ns2cyc(CLKHZ, T1H_NS);
  localparam int NRST = CLKHZ / 1_000_000 * TRST_US;
  localparam int CW   = $clog2(NBIT > NRST ? NBIT : NRST);
  localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam int AW   = BANK_NUM * NPIX > 1 ? $clog2(BANK_NUM * NPIX) : 1;
  if (N0H == 0 || N1H >= NBIT) begin : g_bad_timing
    $error("ws2812_tx: bit timing needs N0H > 0 and N1H < NBIT");
  end
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [4:0]    r_bit, w_bit_n;
  logic [PW-1:0] r_pix, w_pix_n;
  logic          r_busy, r_done, w_load, w_shift;
  logic          w_bit_end, w_pix_end, w_last_pix, w_gap_end;
  assign w_bit_end  = r_cnt == CW'(NBIT - 1);
  assign w_pix_end  = r_bit == 5'd23;
  assign w_last_pix = r_pix == PW'(NPIX - 1);
  assign w_gap_end  = r_cnt == CW'(NRST - 1);
  // w_pix_n doubles as the pixel index to latch whenever w_load is set
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_pix_n   = r_pix;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      IDLE: w_state_n = en ? LOAD : IDLE;
      LOAD: begin
        w_load    = 1'b1;
        w_cnt_n   = '0;
        w_bit_n   = '0;
        w_pix_n   = '0;
        w_state_n = SEND;
      end
      SEND: begin
        w_cnt_n = w_bit_end ? '0 : r_cnt + 1'b1;
        w_shift = w_bit_end;
        if (w_bit_end) begin
          w_bit_n = w_pix_end ? '0 : r_bit + 1'b1;
          if (w_pix_end) begin
            if (w_last_pix) w_state_n = GAP;
            else begin
              w_pix_n = r_pix + 1'b1;
              w_load  = 1'b1;
            end
          end
        end
      end
      GAP: begin
        w_cnt_n   = w_gap_end ? '0 : r_cnt + 1'b1;
        w_state_n = w_gap_end ? IDLE : GAP;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_pix   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_pix   <= w_pix_n;
      r_busy  <= w_state_n != IDLE;
      r_done  <= w_state_n == GAP && w_cnt_n == CW'(NRST - 1);
    end
  end
  assign busy       = r_busy;
  assign frame_done = r_done;
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [AW-1:0] w_idx;
    assign w_idx = AW'(b * NPIX) + AW'(w_pix_n);
    ws2812_bit_encoder #(.CW(CW), .N0H(N0H), .N1H(N1H)) u_enc (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_send  (r_state == SEND),
      .i_pix   (grb(wscolor[w_idx])),
      .i_cnt   (r_cnt),
      .o_dout  (dout[b])
    );
  end
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: directed checks of bit timing, frame length, refresh and reset for a 2-bank 2x2 setup
module tb_ws2812_tx;
  logic        clk, rst, en, busy, frame_done;
  logic [1:0]  dout;
  logic [23:0] wscolor [8];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  logic        mon = 1'b0;
  logic [1:0]  prv = 2'b00;
  int          hc0 = 0, hc1 = 0, lr0 = -1, skew = 0;
  int          wq0[$], wq1[$], pq0[$];

  ws2812_tx #(.BANK_NUM(2), .BANK_X(2), .BANK_Y(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wscolor    (wscolor),
    .en         (en),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int expw(input logic [23:0] rgb, input int i);
    logic [23:0] g;
    g = {rgb[15:8], rgb[23:16], rgb[7:0]};
    return g[23-i] ? 80 : 40;
  endfunction

  // pulse-width, rise-period and bank-skew recorder
  initial forever begin
    @(negedge clk);
    if (mon) begin
      if (dout[0]) hc0++;
      else if (prv[0]) begin wq0.push_back(hc0); hc0 = 0; end
      if (dout[1]) hc1++;
      else if (prv[1]) begin wq1.push_back(hc1); hc1 = 0; end
      if (dout[0] && !prv[0]) begin
        if (lr0 >= 0) pq0.push_back(cyc - lr0);
        lr0 = cyc;
      end
      if ((dout[0] && !prv[0]) != (dout[1] && !prv[1])) skew++;
    end
    prv = dout;
  end

  initial begin
    int n, nd, dn_at, k, w, bad, mx, low_run;
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 8; i++) wscolor[i] = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    k = 0;
    repeat (1000) begin
      @(negedge clk);
      if (dout != 0 || busy || frame_done) k++;
    end
    chk("idle_quiet", k, 0);

    wscolor[0] = 24'hFF0000;
    for (int i = 4; i < 8; i++) wscolor[i] = 24'h000001;
    en  = 1'b1;
    mon = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n  = 1;
    chk("load_busy", busy, 1);
    chk("load_dout", dout, 0);
    nd = 0;
    dn_at = 0;
    while (busy && n < 50000) begin
      if (frame_done) begin nd++; dn_at = n; end
      @(negedge clk);
      n++;
      if (n == 2) chk("send0_dout", dout, 0);
      if (n == 3) chk("first_rise", dout, 3);
    end
    chk("busy_len", n - 1, 42001);
    chk("done_cnt", nd, 1);
    chk("done_at", dn_at, 42001);
    chk("done_after", frame_done, 0);
    mon = 1'b0;
    chk("b0_pulses", wq0.size(), 96);
    chk("b1_pulses", wq1.size(), 96);
    chk("b0_periods", pq0.size(), 95);
    chk("bank_skew", skew, 0);
    if (wq0.size() == 96 && wq1.size() == 96) begin
      chk("b0_g7", wq0[0], 40);
      chk("b0_r7", wq0[8], 80);
      chk("b0_r0", wq0[15], 80);
      chk("b0_b0", wq0[23], 40);
      chk("b1_b1", wq1[22], 40);
      chk("b1_b0", wq1[23], 80);
      chk("b1_p3_b0", wq1[95], 80);
    end
    bad = 0;
    mx  = 0;
    for (int i = 0; i < wq0.size() && i < 96; i++) begin
      if (wq0[i] != expw(wscolor[i/24], i % 24)) bad++;
      if (i >= 24 && wq0[i] > mx) mx = wq0[i];
    end
    for (int i = 0; i < wq1.size() && i < 96; i++)
      if (wq1[i] != expw(wscolor[4 + i/24], i % 24)) bad++;
    chk("width_errs", bad, 0);
    chk("b0_zero_max", mx, 40);
    bad = 0;
    foreach (pq0[i]) if (pq0[i] != 125) bad++;
    chk("period_errs", bad, 0);
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || dout != 0) k++;
    end
    chk("stays_idle", k, 0);

    en = 1'b1;
    k  = 0;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    chk("f2_start", busy, 1);
    k = 0;
    low_run = 0;
    while (!frame_done && k < 50000) begin
      @(negedge clk);
      k++;
      low_run = (dout == 0) ? low_run + 1 : 0;
    end
    chk("f2_done", frame_done, 1);
    wscolor[2] = 24'hFFFFFF;
    @(negedge clk);
    low_run = (dout == 0) ? low_run + 1 : 0;
    chk("f2_idle", busy, 0);
    @(negedge clk);
    chk("f3_load", busy, 1);
    chk("gap_low", int'(low_run >= 30000), 1);

    repeat (6051) @(negedge clk);
    chk("pre_rst_dout", dout, 1);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    rst = 1'b0;
    wscolor[2] = 24'h0;
    wscolor[0] = 24'h00FF00;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("restart_load", busy, 1);
    k = 0;
    while (!dout[0] && k < 10) begin @(negedge clk); k++; end
    chk("restart_rise", k, 2);
    w = 0;
    while (dout[0] && w < 200) begin @(negedge clk); w++; end
    chk("restart_w0", w, 80);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial line driver for WS2812 LED chains. It sits directly downstream of the pixel-colour generator and consumes its `wscolor` array of packed 24-bit `{R,G,B}` words. It drives one single-wire data output per bank, and all banks are transmitted in parallel. Each frame is followed by the WS2812 latch/reset gap, and frames repeat while `en` is held high.

## Interface
- `CLKHZ`, 100_000_000, clk frequency in Hz
- `BANK_NUM`, 1, number of independent LED chains (one `dout` each)
- `BANK_X`, 8, pixels per row
- `BANK_Y`, 8, rows per bank
- `T0H_NS`, 400, high time of a 0 bit
- `T1H_NS`, 800, high time of a 1 bit
- `TBIT_NS`, 1250, total bit period
- `TRST_US`, 300, low time after the frame

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `wscolor`  in  24 x [BANK_NUM*BANK_X*BANK_Y]  pixel colours `{R,G,B}`; bank b pixel p is at index b*BANK_X*BANK_Y+p
- `en`  in  1  level; request continuous refresh
- `dout`  out  [BANK_NUM]  serial data, one per chain
- `busy`  out  1  frame or reset gap in progress
- `frame_done`  out  1  single-cycle pulse at the end of the reset gap

## Operation
- Derived cycle counts (integer, truncating): NBIT=CLKHZ*TBIT_NS/1e9, N0H from T0H_NS, N1H from T1H_NS, NRST=CLKHZ/1e6*TRST_US.
  - At 100 MHz: 125 / 40 / 80 / 30000.
  - Elaboration error if N0H=0 or N1H>=NBIT.
- Wire order per pixel: G[7:0], R[7:0], B[7:0], MSB first. Pixel 0 goes first.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: dout=0, busy=0. If en=1, go to LOAD.
  - LOAD (1 cycle): each bank's shift register latches its pixel 0, reordered to GRB. bit_idx=0, pix=0, cnt=0. Go to SEND.
  - SEND: cnt counts 0..NBIT-1.
    - dout[b]=1 while cnt < (sr[b][23] ? N1H : N0H), otherwise 0.
    - At cnt=NBIT-1: shift left. If bit_idx=23: if pix is the last pixel, go to GAP; otherwise latch the next pixel in the same cycle, so there are no idle cycles between pixels.
  - GAP: dout=0. Count NRST cycles. frame_done=1 on the last GAP cycle, then go to IDLE.
- Each pixel word is sampled at its load edge. The frame is not snapshotted atomically.
- en deasserted mid-frame: the frame and gap complete normally, then the FSM stays in IDLE.
- en held high: the next LOAD follows IDLE one cycle after GAP ends.
- Reset mid-frame: the FSM goes to IDLE and outputs to 0 on the next edge. The chain sees a short pulse plus a low line; the next frame after the gap is valid.

## Timing
- Reset values: dout=0, busy=0, frame_done=0, state IDLE, all counters 0.
- All outputs are registered.
- If en is sampled high at edge k in IDLE, LOAD occurs at k+1 and dout first rises after edge k+2.
- busy is high from the LOAD cycle through the last GAP cycle inclusive.
- Frame time: BANK_X*BANK_Y*24*NBIT cycles of SEND, plus NRST cycles of GAP.
  - Repetition period with en held high: that total + 2 (IDLE + LOAD).
- Every bank's dout toggles on identical edges. Only the high widths differ, by data.

## Structure
- Package `ws2812_pkg`:
  - state enum {IDLE, LOAD, SEND, GAP}
  - function `ns2cyc(clkhz, ns)`
  - GRB reorder function
  - default timing constants
- Sub-module `ws2812_bit_encoder`, one instance per bank:
  - 24-bit shift register with load/shift inputs
  - pulse comparator producing its dout bit from the shared cnt
- The top level holds the shared FSM, cnt, bit_idx and pix counters, sized with $clog2.

## Test plan
Bench setup for all scenarios: CLKHZ=100e6, BANK_NUM=2, BANK_X=BANK_Y=2.

1. Reset: rst=1 for 3 cycles, en=0 → dout=00, busy=0, frame_done=0; no activity for 1000 cycles.
2. Bank0 pixel0=24'hFF0000 (red), en=1 → bank0:
   - first 8 bits high 40 cycles each (G=00)
   - next 8 bits high 80 cycles (R=FF)
   - last 8 bits high 40 cycles
   - every bit period is exactly 125 cycles.
3. Whole frame with en pulsed for 1 cycle:
   - busy high for 2+4*24*125+30000−1 cycles
   - single frame_done pulse on the last GAP cycle
   - then IDLE.
4. Bank1 all 24'h000001 while bank0 is all zero:
   - dout[1] high 80 cycles exactly on each pixel's bit 23
   - dout[0] is never high for more than 40 cycles
   - both rise on the same edges.
5. en held high: next LOAD one cycle after the frame_done cycle; dout low for ≥30000 cycles between frames.
6. rst asserted mid-pixel (cnt=50, pix=2) → next edge: dout=0, busy=0, IDLE; restarts from pixel 0 when en=1.
